cva6_rvfi_commit_tracker: RTL
=============================

Name: cva6_rvfi_commit_tracker

Overview:
Sequential tracking stage that turns the raw per-cycle issue/commit probes into per-retirement RVFI records.
- Captures instruction word and operand values at issue in a table indexed by transaction ID.
- Looks the entry up again when that transaction ID commits.
- Emits one registered record per commit port, carrying a monotonically increasing retirement order number.
- Sits between probe collection and the RVFI trace/checker consumers.

Parameters:
NR_ISSUE_PORTS, 1, number of issue ports
NR_COMMIT_PORTS, 2, number of commit ports
TRANS_ID_BITS, 3, transaction ID width; table depth is 2**TRANS_ID_BITS
XLEN, 64, register data width
VLEN, 64, PC width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; invalidates all table entries
issue_ack_i  in  NR_ISSUE_PORTS  issue handshake completed on this port
issue_pointer_i  in  NR_ISSUE_PORTSxTRANS_ID_BITS  table index written at issue
instruction_i  in  NR_ISSUE_PORTSx32  raw instruction bits
is_compressed_i  in  NR_ISSUE_PORTS  instruction is 16-bit
rs1_val_i / rs2_val_i  in  NR_ISSUE_PORTSxXLEN  forwarded operand values at issue
commit_ack_i  in  NR_COMMIT_PORTS  port retires this cycle
commit_drop_i  in  NR_COMMIT_PORTS  retirement is dropped (no record)
commit_pointer_i  in  NR_COMMIT_PORTSxTRANS_ID_BITS  table index read at commit
commit_pc_i  in  NR_COMMIT_PORTSxVLEN  PC of committing instruction
commit_rd_i  in  NR_COMMIT_PORTSx5  destination register
commit_wdata_i  in  NR_COMMIT_PORTSxXLEN  register write data
ex_valid_i  in  1  exception at commit port 0
ex_cause_i  in  XLEN  exception cause
priv_lvl_i  in  2  current privilege level
rvfi_valid_o  out  NR_COMMIT_PORTS  record valid
rvfi_order_o  out  NR_COMMIT_PORTSx64  retirement order
rvfi_insn_o  out  NR_COMMIT_PORTSx32  instruction bits (upper 16 zeroed if compressed)
rvfi_trap_o  out  NR_COMMIT_PORTS  record is a trap
rvfi_cause_o  out  XLEN  cause, valid with rvfi_trap_o[0]
rvfi_pc_rdata_o  out  NR_COMMIT_PORTSxVLEN  PC
rvfi_rs1_rdata_o / rvfi_rs2_rdata_o  out  NR_COMMIT_PORTSxXLEN  operand values
rvfi_rd_addr_o  out  NR_COMMIT_PORTSx5  rd (0 on trap)
rvfi_rd_wdata_o  out  NR_COMMIT_PORTSxXLEN  rd data (0 when rd=0 or trap)
rvfi_mode_o  out  2  privilege level of the retired records
lookup_err_o  out  1  a commit read an invalid entry

Behaviour:
Reset:
- On async reset, all outputs are 0, the order counter is 0, and all table valid bits are cleared.
- Reset mid-stream discards in-flight records with no glitch.

Table:
- Each entry holds {valid, insn[31:0], compressed, rs1, rs2}.
- Issue write occurs when issue_ack_i[k] is high and flush_i is low.
- If two issue ports write the same index in one cycle, the higher port wins.

Commit:
- A port is active when commit_ack_i[j] is high, or when j=0 and ex_valid_i is high.
- Entry lookup is combinational; all outputs are registered, so latency is exactly 1 cycle from commit to rvfi_valid_o.
- A committed entry's valid bit clears at the edge.
- Same-index issue write and commit read in one cycle: the read returns the old content; the new write sets valid=1 (write wins).

Drop:
- ack together with drop clears the entry.
- rvfi_valid_o[j]=0 and the order number is not consumed.

Order numbering:
- Non-dropped active ports are numbered in ascending port index: order = cnt + rank.
- cnt increments by the count of emitted records.
- cnt is 64-bit and wraps to 0 after 2^64-1.

Exception (ex_valid_i):
- Port 0 emits trap=1, cause=ex_cause_i, rd_addr=0, rd_wdata=0.
- All ports above 0 are suppressed that cycle.
- The counter increments by 1.

Flush:
- Commits in the same cycle are still emitted.
- All valid bits clear at the edge.
- Same-cycle issue writes are discarded.

Lookup error:
- Committing an invalid entry still emits the record, with insn=0 and rs values=0.
- lookup_err_o pulses for 1 cycle, registered alongside the record.

rvfi_mode_o is the registered priv_lvl_i.

Optional Feature:
RVFI_RSVAL_CAPTURE_EN
- Defined: rs1/rs2 values are stored per entry and reported on rvfi_rs1_rdata_o/rvfi_rs2_rdata_o.
- Undefined: no rs storage in the table; rvfi_rs1_rdata_o and rvfi_rs2_rdata_o are tied to 0. All other behaviour is unchanged.

Test Plan:
- Basic retire: issue ptr 2, insn 0x00500093, rs1=0x11; commit ptr 2 next cycle → one cycle later valid[0]=1, order=0, insn=0x00500093, rs1_rdata=0x11 (macro on) / 0 (macro off).
- Dual retire with drop: commit ports 0 and 1 with drop[0]=1 → only valid[1]=1 with order=cnt; cnt+1 afterwards.
- Exception: ex_valid=1, cause=2, ack=2'b11 → valid=2'b01, trap[0]=1, cause=2, rd_wdata=0; cnt+1.
- Flush race: issue ptr 5 plus flush in the same cycle; commit ptr 5 later → record emitted with insn=0 and lookup_err_o=1.
- Read-before-write: commit ptr 3 (old insn A) while issuing ptr 3 with insn B → record shows A; a later commit ptr 3 shows B.
- Order wrap: force cnt=2^64-1, retire 2 → orders 0xFFFF_FFFF_FFFF_FFFF and 0; cnt=1 afterwards.

Source files
------------

// File: rtl/cva6_rvfi_commit_tracker.sv
// RVFI commit tracker: records insn/operands at issue by transaction ID and
// emits one registered RVFI record per committing port with a 64-bit order.
//
// Ports
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i                  invalidates every table entry, drops same-cycle issue writes
//   issue_*                  per issue port: ack, table index, insn, compressed flag, rs values
//   commit_*                 per commit port: ack, drop, table index, pc, rd, write data
//   ex_valid_i, ex_cause_i   exception on commit port 0
//   priv_lvl_i               current privilege level
//   rvfi_*                   registered retirement records, valid one cycle after commit
//   lookup_err_o             a record in this cycle read an invalid table entry
//
// Optional feature macro: RVFI_RSVAL_CAPTURE_EN
//   defined   : rs1/rs2 values stored per entry and reported
//   undefined : no rs storage, rvfi_rs1_rdata_o / rvfi_rs2_rdata_o tied to 0
module cva6_rvfi_commit_tracker #(
    parameter int unsigned NR_ISSUE_PORTS  = 1,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned VLEN            = 64
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           flush_i,
    input  logic [NR_ISSUE_PORTS-1:0]                      issue_ack_i,
    input  logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0]   issue_pointer_i,
    input  logic [NR_ISSUE_PORTS-1:0][31:0]                instruction_i,
    input  logic [NR_ISSUE_PORTS-1:0]                      is_compressed_i,
    input  logic [NR_ISSUE_PORTS-1:0][XLEN-1:0]            rs1_val_i,
    input  logic [NR_ISSUE_PORTS-1:0][XLEN-1:0]            rs2_val_i,
    input  logic [NR_COMMIT_PORTS-1:0]                     commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0]                     commit_drop_i,
    input  logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0]  commit_pointer_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]           commit_pc_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]                commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           commit_wdata_i,
    input  logic                                           ex_valid_i,
    input  logic [XLEN-1:0]                                ex_cause_i,
    input  logic [1:0]                                     priv_lvl_i,
    output logic [NR_COMMIT_PORTS-1:0]                     rvfi_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][63:0]               rvfi_order_o,
    output logic [NR_COMMIT_PORTS-1:0][31:0]               rvfi_insn_o,
    output logic [NR_COMMIT_PORTS-1:0]                     rvfi_trap_o,
    output logic [XLEN-1:0]                                rvfi_cause_o,
    output logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]           rvfi_pc_rdata_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           rvfi_rs1_rdata_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           rvfi_rs2_rdata_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]                rvfi_rd_addr_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]           rvfi_rd_wdata_o,
    output logic [1:0]                                     rvfi_mode_o,
    output logic                                           lookup_err_o
);

    localparam int unsigned DEPTH = 1 << TRANS_ID_BITS;

    // transaction table
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] comp_q, comp_d;
    logic [31:0]      insn_q [DEPTH];
    logic [31:0]      insn_d [DEPTH];
`ifdef RVFI_RSVAL_CAPTURE_EN
    logic [XLEN-1:0]  rs1_q [DEPTH];
    logic [XLEN-1:0]  rs1_d [DEPTH];
    logic [XLEN-1:0]  rs2_q [DEPTH];
    logic [XLEN-1:0]  rs2_d [DEPTH];
`else
    logic             unused_rs;
    assign unused_rs = ^{rs1_val_i, rs2_val_i};
`endif

    logic [63:0] cnt_q, cnt_d;
    logic [63:0] run;

    logic [NR_COMMIT_PORTS-1:0] active;
    logic [NR_COMMIT_PORTS-1:0] emit;
    logic [NR_COMMIT_PORTS-1:0] hit;
    logic [NR_COMMIT_PORTS-1:0] rec_trap;

    logic [NR_COMMIT_PORTS-1:0][63:0]      rec_order;
    logic [NR_COMMIT_PORTS-1:0][31:0]      rec_insn;
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]  rec_pc;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  rec_rs1;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  rec_rs2;
    logic [NR_COMMIT_PORTS-1:0][4:0]       rec_rd;
    logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  rec_wdata;
    logic [XLEN-1:0]                       rec_cause;
    logic                                  rec_err;

    // An exception claims port 0 and silences every higher port; dropped
    // retirements are active (they clear their entry) but emit nothing.
    always_comb begin
        active = '0;
        emit   = '0;
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            active[j] = commit_ack_i[j];
            emit[j]   = commit_ack_i[j] & ~commit_drop_i[j];
        end
        if (ex_valid_i) begin
            active    = '0;
            emit      = '0;
            active[0] = 1'b1;
            emit[0]   = 1'b1;
        end
    end

    // Emitted ports take consecutive order numbers in port order.
    always_comb begin
        run = cnt_q;
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            rec_order[j] = '0;
            if (emit[j]) begin
                rec_order[j] = run;
                run          = run + 64'd1;
            end
        end
        cnt_d = run;
    end

    // Record assembly from the pre-edge table contents.
    always_comb begin
        hit       = '0;
        rec_trap  = '0;
        rec_insn  = '0;
        rec_pc    = '0;
        rec_rs1   = '0;
        rec_rs2   = '0;
        rec_rd    = '0;
        rec_wdata = '0;
        rec_cause = '0;
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            hit[j] = valid_q[commit_pointer_i[j]];
            if (emit[j]) begin
                rec_pc[j] = commit_pc_i[j];
                if (hit[j]) begin
                    if (comp_q[commit_pointer_i[j]]) begin
                        rec_insn[j] = {16'h0, insn_q[commit_pointer_i[j]][15:0]};
                    end else begin
                        rec_insn[j] = insn_q[commit_pointer_i[j]];
                    end
`ifdef RVFI_RSVAL_CAPTURE_EN
                    rec_rs1[j] = rs1_q[commit_pointer_i[j]];
                    rec_rs2[j] = rs2_q[commit_pointer_i[j]];
`endif
                end
                if (j == 0 && ex_valid_i) begin
                    rec_trap[j] = 1'b1;
                end else begin
                    rec_rd[j] = commit_rd_i[j];
                    if (commit_rd_i[j] != 5'd0) begin
                        rec_wdata[j] = commit_wdata_i[j];
                    end
                end
            end
        end
        if (ex_valid_i) begin
            rec_cause = ex_cause_i;
        end
        rec_err = |(emit & ~hit);
    end

    // Commit clears first, then issue writes so a same-index write wins;
    // ascending port loop lets the higher issue port win; flush beats all.
    always_comb begin
        valid_d = valid_q;
        comp_d  = comp_q;
        insn_d  = insn_q;
`ifdef RVFI_RSVAL_CAPTURE_EN
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
`endif
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            if (active[j]) begin
                valid_d[commit_pointer_i[j]] = 1'b0;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int k = 0; k < NR_ISSUE_PORTS; k++) begin
                if (issue_ack_i[k]) begin
                    valid_d[issue_pointer_i[k]] = 1'b1;
                    comp_d[issue_pointer_i[k]]  = is_compressed_i[k];
                    insn_d[issue_pointer_i[k]]  = instruction_i[k];
`ifdef RVFI_RSVAL_CAPTURE_EN
                    rs1_d[issue_pointer_i[k]]   = rs1_val_i[k];
                    rs2_d[issue_pointer_i[k]]   = rs2_val_i[k];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            comp_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                insn_q[i] <= '0;
`ifdef RVFI_RSVAL_CAPTURE_EN
                rs1_q[i]  <= '0;
                rs2_q[i]  <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            comp_q  <= comp_d;
            cnt_q   <= cnt_d;
            insn_q  <= insn_d;
`ifdef RVFI_RSVAL_CAPTURE_EN
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvfi_valid_o     <= '0;
            rvfi_order_o     <= '0;
            rvfi_insn_o      <= '0;
            rvfi_trap_o      <= '0;
            rvfi_cause_o     <= '0;
            rvfi_pc_rdata_o  <= '0;
            rvfi_rs1_rdata_o <= '0;
            rvfi_rs2_rdata_o <= '0;
            rvfi_rd_addr_o   <= '0;
            rvfi_rd_wdata_o  <= '0;
            rvfi_mode_o      <= '0;
            lookup_err_o     <= 1'b0;
        end else begin
            rvfi_valid_o     <= emit;
            rvfi_order_o     <= rec_order;
            rvfi_insn_o      <= rec_insn;
            rvfi_trap_o      <= rec_trap;
            rvfi_cause_o     <= rec_cause;
            rvfi_pc_rdata_o  <= rec_pc;
            rvfi_rs1_rdata_o <= rec_rs1;
            rvfi_rs2_rdata_o <= rec_rs2;
            rvfi_rd_addr_o   <= rec_rd;
            rvfi_rd_wdata_o  <= rec_wdata;
            rvfi_mode_o      <= priv_lvl_i;
            lookup_err_o     <= rec_err;
        end
    end

endmodule
